// File: rtl/memory_arbiter.sv
// Shares one single-ported memory between the ifetch and load/store ports.
// Define ARB_ROUND_ROBIN_EN for round-robin; default is data-first with starvation guard.
module memory_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [31:0] d_mask,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] read_memory_address,
    input  logic [31:0] read_memory_data,
    output logic [31:0] write_memory_address,
    output logic [31:0] write_memory_data,
    output logic [31:0] write_memory_mask,
    output logic        memory_write_enable
);

    typedef enum logic [1:0] {
        IDLE,
        RD_I,
        RD_D
    } state_t;

    state_t      state;
    logic [31:0] raddr_q;
    logic [31:0] waddr_q;
    logic [31:0] wdata_q;
    logic [31:0] wmask_q;
    logic        i_win;
    logic        d_rd;
    logic        d_wr;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when ifetch holds the most recent grant; reset state lets data win first.
    logic i_last;

    assign i_win = !i_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_last <= 1'b1;
        end else if (i_gnt) begin
            i_last <= 1'b1;
        end else if (d_gnt) begin
            i_last <= 1'b0;
        end
    end
`else
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;

    assign i_win = (starve_cnt == CW'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (!i_req || i_gnt) begin
            starve_cnt <= '0;
        end else if (!i_win) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        i_gnt = reset && i_req && (!d_req || i_win);
        d_gnt = reset && d_req && (!i_req || !i_win);
        d_rd  = d_gnt && !d_we;
        d_wr  = d_gnt && d_we;
    end

    always_comb begin
        read_memory_address = raddr_q;
        if (i_gnt) begin
            read_memory_address = i_addr;
        end else if (d_rd) begin
            read_memory_address = d_addr;
        end
    end

    assign write_memory_address = d_wr ? d_addr  : waddr_q;
    assign write_memory_data    = d_wr ? d_wdata : wdata_q;
    assign write_memory_mask    = d_wr ? d_mask  : wmask_q;
    assign memory_write_enable  = d_wr;

    assign i_rvalid = (state == RD_I);
    assign d_rvalid = (state == RD_D);
    assign i_rdata  = read_memory_data;
    assign d_rdata  = read_memory_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            raddr_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            raddr_q <= read_memory_address;
            waddr_q <= write_memory_address;
            wdata_q <= write_memory_data;
            wmask_q <= write_memory_mask;
            if (i_gnt) begin
                state <= RD_I;
            end else if (d_rd) begin
                state <= RD_D;
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule
